relu_stream_ctrl: RTL and testbench

RELU_STREAM_CTRL -- requirements
Module: relu_stream_ctrl

---
 rtl/relu_pkg.sv | 24 ++
 rtl/relu_addr_gen.sv | 44 ++++
 rtl/relu_stream_ctrl.sv | 122 ++++++++++++
 tb/tb_relu_stream_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/relu_pkg.sv
// Shared types and sizing helpers for the ReLU stream controller.
// The optional RELU_CTRL_PERF_EN build adds a busy-cycle counter to the top.
package relu_pkg;

  localparam int BUS_NUM_DEF          = 8;
  localparam int FIXED_DATA_WIDTH_DEF = 8;
  localparam int MEM_DEPTH_DEF        = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int word_width(input int lanes, input int lane_w);
    return lanes * lane_w;
  endfunction

endpackage

// File: rtl/relu_addr_gen.sv
// Job address/count generator: latches a base on load, counts beats on adv,
// and presents base+count wrapped modulo MEM_DEPTH.
module relu_addr_gen
  import relu_pkg::*;
#(
  parameter  int MEM_DEPTH  = MEM_DEPTH_DEF,
  localparam int ADDR_WIDTH = addr_width(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  adv,
  input  logic [ADDR_WIDTH-1:0] base,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH:0]   cnt
);

  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH+1:0] sum;
  logic [1:0]            unused_sum_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      cnt    <= '0;
    end else if (load) begin
      base_q <= base;
      cnt    <= '0;
    end else if (adv) begin
      cnt    <= cnt + (ADDR_WIDTH+1)'(1);
    end
  end

  // Single conditional subtract suffices: base < MEM_DEPTH and cnt < MEM_DEPTH.
  always_comb begin
    sum = {2'b00, base_q} + {1'b0, cnt};
    if (sum >= (ADDR_WIDTH+2)'(MEM_DEPTH))
      sum = sum - (ADDR_WIDTH+2)'(MEM_DEPTH);
  end

  assign addr          = sum[ADDR_WIDTH-1:0];
  assign unused_sum_hi = sum[ADDR_WIDTH+1:ADDR_WIDTH];

endmodule

// File: rtl/relu_stream_ctrl.sv
// Streams len words from src_base through an external ReLU array into dst_base.
// Define RELU_CTRL_PERF_EN to add the perf_cycles busy-cycle counter output.
module relu_stream_ctrl
  import relu_pkg::*;
#(
  parameter  int BUS_NUM          = BUS_NUM_DEF,
  parameter  int FIXED_DATA_WIDTH = FIXED_DATA_WIDTH_DEF,
  parameter  int MEM_DEPTH        = MEM_DEPTH_DEF,
  localparam int ADDR_WIDTH       = addr_width(MEM_DEPTH),
  localparam int DW               = word_width(BUS_NUM, FIXED_DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DW-1:0]         mem_rd_data,
  output logic [DW-1:0]         relu_in_data,
  output logic [BUS_NUM-1:0]    relu_in_vld,
  input  logic [DW-1:0]         relu_out_data,
  input  logic [BUS_NUM-1:0]    relu_out_vld,
`ifdef RELU_CTRL_PERF_EN
  output logic [31:0]           perf_cycles,
`endif
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DW-1:0]         mem_wr_data
);

  state_t                state, state_nx;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   rd_cnt, wr_cnt, wr_cnt_nx;
  logic                  accept, rd_en, rd_vld_q, beat, wr_ok;

  assign busy      = (state != IDLE);
  assign accept    = start && (state == IDLE);
  assign rd_en     = (state == RUN) && (rd_cnt != len_q);
  // Any lane valid consumes a write slot; only a full-width beat is written.
  assign beat      = busy && (|relu_out_vld);
  assign wr_ok     = busy && (&relu_out_vld);
  assign wr_cnt_nx = wr_cnt + (ADDR_WIDTH+1)'(beat);

  relu_addr_gen #(.MEM_DEPTH(MEM_DEPTH)) u_rd_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .adv   (rd_en),
    .base  (src_base),
    .addr  (mem_rd_addr),
    .cnt   (rd_cnt)
  );

  relu_addr_gen #(.MEM_DEPTH(MEM_DEPTH)) u_wr_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .adv   (beat),
    .base  (dst_base),
    .addr  (mem_wr_addr),
    .cnt   (wr_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      len_q    <= '0;
      rd_vld_q <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      rd_vld_q <= rd_en;
      if (accept) begin
        len_q <= len;
        err   <= 1'b0;
      end else if (beat && !wr_ok) begin
        err   <= 1'b1;
      end
    end
  end

  // A zero-length job passes through RUN for one cycle with no reads.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN: begin
        if (len_q == '0)
          state_nx = FIN;
        else if (rd_cnt == len_q - (ADDR_WIDTH+1)'(1))
          state_nx = DRAIN;
      end
      DRAIN:   if (wr_cnt_nx == len_q) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign done         = (state == FIN);
  assign mem_rd_en    = rd_en;
  assign relu_in_vld  = {BUS_NUM{rd_vld_q}};
  assign relu_in_data = rd_vld_q ? mem_rd_data : '0;
  assign mem_wr_en    = wr_ok;
  assign mem_wr_data  = wr_ok ? relu_out_data : '0;

`ifdef RELU_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      perf_cycles <= '0;
    else if (accept)
      perf_cycles <= '0;
    else if (busy)
      perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_relu_stream_ctrl.sv
// Scoreboard bench for relu_stream_ctrl with behavioural memory and ReLU array models.
module tb_relu_stream_ctrl;
  localparam int BN = 8, FW = 8, DEPTH = 512, AW = 9, DW = 64;

  logic          clk = 0, rst_n = 0, start = 0;
  logic [AW-1:0] src_base = '0, dst_base = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, err, mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [DW-1:0] mem_rd_data, relu_in_data, relu_out_data, mem_wr_data;
  logic [BN-1:0] relu_in_vld, relu_out_vld;
`ifdef RELU_CTRL_PERF_EN
  logic [31:0]   perf_cycles;
`endif

  always #5 clk = ~clk;

  relu_stream_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_base(src_base), .dst_base(dst_base),
    .len(len), .busy(busy), .done(done), .err(err),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .relu_in_data(relu_in_data), .relu_in_vld(relu_in_vld),
    .relu_out_data(relu_out_data), .relu_out_vld(relu_out_vld),
`ifdef RELU_CTRL_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
  );

  logic [DW-1:0] mem [DEPTH];
  int tot = 0, bad = 0;
  int cyc = 0, start_cyc = 0;
  logic force_en = 0;
  int force_idx = 0, beat_idx = 0;

  logic [AW-1:0] got_wa[$], got_ra[$], exp_wa[$], exp_ra[$];
  logic [DW-1:0] got_wd[$], exp_wd[$];
  int            got_done[$];

  function automatic logic [DW-1:0] relu_word(input logic [DW-1:0] x);
    logic [DW-1:0] r;
    for (int j = 0; j < BN; j++)
      r[j*FW +: FW] = x[j*FW+FW-1] ? '0 : x[j*FW +: FW];
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) mem_rd_data <= '0;
    else if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      relu_out_data <= '0; relu_out_vld <= '0; beat_idx <= 0;
    end else begin
      relu_out_data <= relu_word(relu_in_data);
      relu_out_vld  <= '0;
      if (start && !busy) beat_idx <= 0;
      else if (|relu_in_vld) begin
        relu_out_vld <= (force_en && beat_idx == force_idx) ? 8'h0F : relu_in_vld;
        beat_idx     <= beat_idx + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mem_wr_en) begin got_wa.push_back(mem_wr_addr); got_wd.push_back(mem_wr_data); end
    if (mem_rd_en) got_ra.push_back(mem_rd_addr);
    if (done) got_done.push_back(cyc - start_cyc);
  end

  task automatic clear_q;
    got_wa.delete(); got_wd.delete(); got_ra.delete(); got_done.delete();
    exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
  endtask

  task automatic launch(input int s, input int d, input int l);
    @(posedge clk); #1;
    src_base = AW'(s); dst_base = AW'(d); len = (AW+1)'(l); start = 1;
    @(posedge clk); #1;
    start = 0; start_cyc = cyc - 1;
  endtask

  task automatic expect_job(input int s, input int d, input int l);
    for (int i = 0; i < l; i++) begin
      exp_ra.push_back(AW'((s + i) % DEPTH));
      exp_wa.push_back(AW'((d + i) % DEPTH));
      exp_wd.push_back(relu_word(mem[(s + i) % DEPTH]));
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tot++; if ({busy, done, err, mem_rd_en, mem_wr_en} !== 5'b0) begin bad++;
      $display("FAIL reset_ctl got=%b exp=00000", {busy, done, err, mem_rd_en, mem_wr_en}); end
    tot++; if (relu_in_vld !== '0) begin bad++; $display("FAIL reset_vld got=%h exp=0", relu_in_vld); end
    tot++; if ({mem_rd_addr, mem_wr_addr} !== '0) begin bad++;
      $display("FAIL reset_addr got=%0d/%0d exp=0/0", mem_rd_addr, mem_wr_addr); end
    @(posedge clk); #1 rst_n = 1;
  endtask

  task automatic test_basic;
    logic [DW-1:0] w, want;
    w = {4{8'hFD, 8'h05}}; want = {4{8'h00, 8'h05}};
    clear_q();
    for (int i = 0; i < 4; i++) begin
      mem[i] = w; exp_ra.push_back(AW'(i)); exp_wa.push_back(AW'(100 + i)); exp_wd.push_back(want);
    end
    launch(0, 100, 4);
    repeat (12) @(posedge clk); #1;
    tot++; if (got_ra.size() != exp_ra.size()) begin bad++;
      $display("FAIL basic_rd_count got=%0d exp=%0d", got_ra.size(), exp_ra.size()); end
    while (exp_ra.size() > 0 && got_ra.size() > 0) begin
      logic [AW-1:0] a, e; a = got_ra.pop_front(); e = exp_ra.pop_front();
      tot++; if (a !== e) begin bad++; $display("FAIL basic_rd_addr got=%0d exp=%0d", a, e); end
    end
    tot++; if (got_wa.size() != exp_wa.size()) begin bad++;
      $display("FAIL basic_wr_count got=%0d exp=%0d", got_wa.size(), exp_wa.size()); end
    while (exp_wa.size() > 0 && got_wa.size() > 0) begin
      logic [AW-1:0] a, ea; logic [DW-1:0] dd, ed;
      a = got_wa.pop_front(); ea = exp_wa.pop_front(); dd = got_wd.pop_front(); ed = exp_wd.pop_front();
      tot++; if (a !== ea || dd !== ed) begin bad++;
        $display("FAIL basic_wr got=%0d:%h exp=%0d:%h", a, dd, ea, ed); end
    end
    tot++; if (got_done.size() != 1 || got_done[0] != 7) begin bad++;
      $display("FAIL basic_done got=%p exp='{7}", got_done); end
    tot++; if (err !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL basic_end got err=%b busy=%b exp 0/0", err, busy); end
`ifdef RELU_CTRL_PERF_EN
    tot++; if (perf_cycles !== 32'd7) begin bad++; $display("FAIL perf got=%0d exp=7", perf_cycles); end
`endif
  endtask

  task automatic test_len_zero;
    clear_q();
    launch(5, 7, 0);
    repeat (6) @(posedge clk); #1;
    tot++; if (got_ra.size() != 0 || got_wa.size() != 0) begin bad++;
      $display("FAIL zero_traffic got rd=%0d wr=%0d exp 0/0", got_ra.size(), got_wa.size()); end
    tot++; if (got_done.size() != 1 || got_done[0] != 2) begin bad++;
      $display("FAIL zero_done got=%p exp='{2}", got_done); end
  endtask

  task automatic test_wrap;
    clear_q();
    mem[510] = {$urandom, $urandom}; mem[511] = {$urandom, $urandom};
    mem[0] = {$urandom, $urandom};   mem[1] = {$urandom, $urandom};
    expect_job(510, 20, 4);
    launch(510, 20, 4);
    repeat (12) @(posedge clk); #1;
    tot++; if (got_ra.size() != 4) begin bad++; $display("FAIL wrap_rd_count got=%0d exp=4", got_ra.size()); end
    while (exp_ra.size() > 0 && got_ra.size() > 0) begin
      logic [AW-1:0] a, e; a = got_ra.pop_front(); e = exp_ra.pop_front();
      tot++; if (a !== e) begin bad++; $display("FAIL wrap_rd_addr got=%0d exp=%0d", a, e); end
    end
    tot++; if (got_wa.size() != 4) begin bad++; $display("FAIL wrap_wr_count got=%0d exp=4", got_wa.size()); end
    while (exp_wa.size() > 0 && got_wa.size() > 0) begin
      logic [AW-1:0] a, ea; logic [DW-1:0] dd, ed;
      a = got_wa.pop_front(); ea = exp_wa.pop_front(); dd = got_wd.pop_front(); ed = exp_wd.pop_front();
      tot++; if (a !== ea || dd !== ed) begin bad++;
        $display("FAIL wrap_wr got=%0d:%h exp=%0d:%h", a, dd, ea, ed); end
    end
  endtask

  task automatic test_err;
    clear_q();
    for (int i = 8; i < 12; i++) mem[i] = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) if (i != 1) begin
      exp_wa.push_back(AW'(300 + i)); exp_wd.push_back(relu_word(mem[8 + i]));
    end
    force_en = 1; force_idx = 1;
    launch(8, 300, 4);
    repeat (12) @(posedge clk); #1;
    force_en = 0;
    tot++; if (err !== 1'b1) begin bad++; $display("FAIL err_flag got=%b exp=1", err); end
    tot++; if (got_wa.size() != 3) begin bad++; $display("FAIL err_wr_count got=%0d exp=3", got_wa.size()); end
    while (exp_wa.size() > 0 && got_wa.size() > 0) begin
      logic [AW-1:0] a, ea; logic [DW-1:0] dd, ed;
      a = got_wa.pop_front(); ea = exp_wa.pop_front(); dd = got_wd.pop_front(); ed = exp_wd.pop_front();
      tot++; if (a !== ea || dd !== ed) begin bad++;
        $display("FAIL err_wr got=%0d:%h exp=%0d:%h", a, dd, ea, ed); end
    end
    tot++; if (got_done.size() != 1 || got_done[0] != 7) begin bad++;
      $display("FAIL err_done got=%p exp='{7}", got_done); end
  endtask

  task automatic test_reset_mid;
    clear_q();
    for (int i = 50; i < 60; i++) mem[i] = {$urandom, $urandom};
    launch(50, 60, 10);
    repeat (3) @(posedge clk); #1;
    rst_n = 0;
    @(negedge clk);
    tot++; if ({busy, done, err, mem_rd_en, mem_wr_en} !== 5'b0 || relu_in_vld !== '0) begin bad++;
      $display("FAIL midrst_ctl got=%b vld=%h exp=0", {busy, done, err, mem_rd_en, mem_wr_en}, relu_in_vld); end
    tot++; if ({mem_rd_addr, mem_wr_addr} !== '0) begin bad++;
      $display("FAIL midrst_addr got=%0d/%0d exp=0/0", mem_rd_addr, mem_wr_addr); end
    @(posedge clk); #1 rst_n = 1;
    clear_q();
    for (int i = 70; i < 73; i++) mem[i] = {$urandom, $urandom};
    expect_job(70, 80, 3);
    launch(70, 80, 3);
    repeat (11) @(posedge clk); #1;
    tot++; if (got_wa.size() != 3) begin bad++; $display("FAIL midrst_wr_count got=%0d exp=3", got_wa.size()); end
    while (exp_wa.size() > 0 && got_wa.size() > 0) begin
      logic [AW-1:0] a, ea; logic [DW-1:0] dd, ed;
      a = got_wa.pop_front(); ea = exp_wa.pop_front(); dd = got_wd.pop_front(); ed = exp_wd.pop_front();
      tot++; if (a !== ea || dd !== ed) begin bad++;
        $display("FAIL midrst_wr got=%0d:%h exp=%0d:%h", a, dd, ea, ed); end
    end
    tot++; if (got_done.size() != 1 || got_done[0] != 6) begin bad++;
      $display("FAIL midrst_done got=%p exp='{6}", got_done); end
  endtask

  task automatic test_busy_restart;
    clear_q();
    for (int i = 40; i < 45; i++) mem[i] = {$urandom, $urandom};
    expect_job(40, 200, 5);
    launch(40, 200, 5);
    @(posedge clk); #1;
    src_base = AW'(300); dst_base = AW'(400); len = (AW+1)'(2); start = 1;
    @(posedge clk); #1 start = 0;
    repeat (12) @(posedge clk); #1;
    tot++; if (got_ra.size() != 5) begin bad++; $display("FAIL restart_rd_count got=%0d exp=5", got_ra.size()); end
    while (exp_ra.size() > 0 && got_ra.size() > 0) begin
      logic [AW-1:0] a, e; a = got_ra.pop_front(); e = exp_ra.pop_front();
      tot++; if (a !== e) begin bad++; $display("FAIL restart_rd_addr got=%0d exp=%0d", a, e); end
    end
    tot++; if (got_wa.size() != 5) begin bad++; $display("FAIL restart_wr_count got=%0d exp=5", got_wa.size()); end
    while (exp_wa.size() > 0 && got_wa.size() > 0) begin
      logic [AW-1:0] a, ea; logic [DW-1:0] dd, ed;
      a = got_wa.pop_front(); ea = exp_wa.pop_front(); dd = got_wd.pop_front(); ed = exp_wd.pop_front();
      tot++; if (a !== ea || dd !== ed) begin bad++;
        $display("FAIL restart_wr got=%0d:%h exp=%0d:%h", a, dd, ea, ed); end
    end
    tot++; if (got_done.size() != 1 || got_done[0] != 8) begin bad++;
      $display("FAIL restart_done got=%p exp='{8}", got_done); end
    tot++; if (err !== 1'b0) begin bad++; $display("FAIL restart_err got=%b exp=0", err); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_len_zero();
    test_wrap();
    test_err();
    test_reset_mid();
    test_busy_restart();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
